// File: rtl/regfile_pkg.sv
// Shared defaults and address-width derivation for the multi-port register file.
package regfile_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;

  function automatic int unsigned aw_of(input int unsigned nregs);
    return (nregs <= 2) ? 1 : $clog2(nregs);
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: read ports, write ports, issue strobe and scoreboard view.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned NRD   = 2,
  parameter int unsigned NWR   = 2
);
  localparam int unsigned AW = aw_of(NREGS);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_pending;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                iss_en;
  logic [AW-1:0]       iss_addr;
  logic [NREGS-1:0]    pend_vec;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    input  rd_data, rd_pending, pend_vec
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    output rd_data, rd_pending, pend_vec
  );

endinterface

// File: rtl/regfile_bypass.sv
// One read port: stored value/pending bit overridden by the highest-index same-cycle write.
module regfile_bypass #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned NWR      = 2,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                rst_n,
  input  logic [AW-1:0]       i_rd_addr,
  input  logic [XLEN-1:0]     i_store_data,
  input  logic                i_store_pend,
  input  logic [NWR-1:0]      i_wr_en,
  input  logic [NWR*AW-1:0]   i_wr_addr,
  input  logic [NWR*XLEN-1:0] i_wr_data,
  output logic [XLEN-1:0]     o_rd_data,
  output logic                o_rd_pending
);

  logic w_is_zero;

  assign w_is_zero = ZERO_REG && (i_rd_addr == '0);

  // Ascending scan so the highest-index matching port is applied last.
  always_comb begin
    o_rd_data    = i_store_data;
    o_rd_pending = i_store_pend;
    if (rst_n && !w_is_zero) begin
      for (int unsigned j = 0; j < NWR; j++) begin
        if (i_wr_en[j] && (i_wr_addr[j*AW +: AW] == i_rd_addr)) begin
          o_rd_data    = i_wr_data[j*XLEN +: XLEN];
          o_rd_pending = 1'b0;
        end
      end
    end
    if (w_is_zero) begin
      o_rd_data    = '0;
      o_rd_pending = 1'b0;
    end
    if (!rst_n) o_rd_data = '0;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write-through bypass and a per-register pending scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter int unsigned NREGS    = NREGS_DEF,
  parameter int unsigned NRD      = 2,
  parameter int unsigned NWR      = 2,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_mp_if.slave  bus
);

  localparam int unsigned AW = aw_of(NREGS);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] r_pend;
  logic             w_iss_ok;

  assign w_iss_ok     = bus.iss_en && !(ZERO_REG && (bus.iss_addr == '0));
  assign bus.pend_vec = r_pend;

  // Writes clear pending first, then an issue re-sets it so a new producer wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_pend <= '0;
    end else begin
      for (int unsigned j = 0; j < NWR; j++) begin
        if (bus.wr_en[j]) begin
          if (!(ZERO_REG && (bus.wr_addr[j*AW +: AW] == '0)))
            r_regs[bus.wr_addr[j*AW +: AW]] <= bus.wr_data[j*XLEN +: XLEN];
          r_pend[bus.wr_addr[j*AW +: AW]] <= 1'b0;
        end
      end
      if (w_iss_ok) r_pend[bus.iss_addr] <= 1'b1;
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0] w_addr;

    assign w_addr = bus.rd_addr[g*AW +: AW];

    regfile_bypass #(
      .XLEN     (XLEN),
      .AW       (AW),
      .NWR      (NWR),
      .ZERO_REG (ZERO_REG)
    ) u_bypass (
      .rst_n        (rst_n),
      .i_rd_addr    (w_addr),
      .i_store_data (r_regs[w_addr]),
      .i_store_pend (r_pend[w_addr]),
      .i_wr_en      (bus.wr_en),
      .i_wr_addr    (bus.wr_addr),
      .i_wr_data    (bus.wr_data),
      .o_rd_data    (bus.rd_data[g*XLEN +: XLEN]),
      .o_rd_pending (bus.rd_pending[g])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed-vector bench for regfile_mp with hand-computed expectations.
module tb_regfile_mp;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned NRD   = 2;
  localparam int unsigned NWR   = 2;
  localparam int unsigned AW    = 5;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) bus ();

  regfile_mp #(
    .XLEN     (XLEN),
    .NREGS    (NREGS),
    .NRD      (NRD),
    .NWR      (NWR),
    .ZERO_REG (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en    = '0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.iss_en   = 1'b0;
    bus.iss_addr = '0;
  endtask

  task automatic set_rd(input int unsigned p, input logic [AW-1:0] a);
    bus.rd_addr[p*AW +: AW] = a;
  endtask

  task automatic set_wr(input int unsigned p, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    bus.wr_en[p]               = 1'b1;
    bus.wr_addr[p*AW +: AW]    = a;
    bus.wr_data[p*XLEN +: XLEN] = d;
  endtask

  function automatic logic [XLEN-1:0] rdd(input int unsigned p);
    return bus.rd_data[p*XLEN +: XLEN];
  endfunction

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.rd_addr = '0;
    idle();
    tick();
    tick();
    rst_n = 1'b1;
    #1;

    check("reset_pend_vec", 64'(bus.pend_vec), 64'h0);
    for (int a = 0; a < 32; a++) begin
      set_rd(0, AW'(a));
      set_rd(1, AW'(31 - a));
      #1;
      check($sformatf("reset_rd0_r%0d", a), 64'(rdd(0)), 64'h0);
      check($sformatf("reset_rd1_r%0d", 31 - a), 64'(rdd(1)), 64'h0);
      check($sformatf("reset_pend_r%0d", a), 64'(bus.rd_pending), 64'h0);
    end

    // single write with same-cycle bypass, then from storage
    set_wr(0, 5'd5, 32'hDEADBEEF);
    set_rd(0, 5'd5);
    set_rd(1, 5'd6);
    #1;
    check("byp_r5", 64'(rdd(0)), 64'hDEADBEEF);
    check("byp_r6_untouched", 64'(rdd(1)), 64'h0);
    tick();
    idle();
    #1;
    check("store_r5", 64'(rdd(0)), 64'hDEADBEEF);

    // two ports same address: port 1 wins
    set_wr(0, 5'd7, 32'h11);
    set_wr(1, 5'd7, 32'h22);
    set_rd(0, 5'd7);
    set_rd(1, 5'd7);
    #1;
    check("byp_prio_p0", 64'(rdd(0)), 64'h22);
    check("byp_prio_p1", 64'(rdd(1)), 64'h22);
    tick();
    idle();
    #1;
    check("store_prio_r7", 64'(rdd(1)), 64'h22);

    // register 0 is hardwired
    set_wr(0, 5'd0, 32'hFFFF_FFFF);
    bus.iss_en   = 1'b1;
    bus.iss_addr = 5'd0;
    set_rd(0, 5'd0);
    set_rd(1, 5'd0);
    #1;
    check("r0_byp", 64'(rdd(0)), 64'h0);
    tick();
    idle();
    #1;
    check("r0_store", 64'(rdd(1)), 64'h0);
    check("r0_pend_vec", 64'(bus.pend_vec), 64'h0);

    // issue then write+issue same address
    bus.iss_en   = 1'b1;
    bus.iss_addr = 5'd9;
    set_rd(0, 5'd9);
    #1;
    check("iss_same_cycle_no_pend", 64'(bus.rd_pending[0]), 64'h0);
    tick();
    idle();
    #1;
    check("iss9_rd_pending", 64'(bus.rd_pending[0]), 64'h1);
    check("iss9_pend_vec", 64'(bus.pend_vec), 64'h0000_0200);
    set_wr(1, 5'd9, 32'h55);
    bus.iss_en   = 1'b1;
    bus.iss_addr = 5'd9;
    set_rd(1, 5'd9);
    #1;
    check("wr_iss9_pending_p0", 64'(bus.rd_pending[0]), 64'h0);
    check("wr_iss9_pending_p1", 64'(bus.rd_pending[1]), 64'h0);
    check("wr_iss9_data", 64'(rdd(0)), 64'h55);
    tick();
    idle();
    #1;
    check("wr_iss9_pend_vec", 64'(bus.pend_vec), 64'h0000_0200);
    check("wr_iss9_rd_pending", 64'(bus.rd_pending), 64'h3);
    check("wr_iss9_store", 64'(rdd(1)), 64'h55);

    // plain write clears pending; other registers unaffected
    bus.iss_en   = 1'b1;
    bus.iss_addr = 5'd12;
    tick();
    idle();
    #1;
    check("iss12_pend_vec", 64'(bus.pend_vec), 64'h0000_1200);
    set_wr(0, 5'd12, 32'hA5A5_0F0F);
    tick();
    idle();
    set_rd(0, 5'd12);
    #1;
    check("wr12_clear_pend", 64'(bus.pend_vec), 64'h0000_0200);
    check("wr12_store", 64'(rdd(0)), 64'hA5A5_0F0F);

    // reset mid-operation discards same-cycle write and issue
    rst_n = 1'b0;
    bus.iss_en   = 1'b1;
    bus.iss_addr = 5'd3;
    set_wr(0, 5'd4, 32'h0000_ABCD);
    set_rd(0, 5'd4);
    set_rd(1, 5'd5);
    #1;
    check("rst_no_bypass", 64'(rdd(0)), 64'h0);
    check("rst_rd_zero_r5", 64'(rdd(1)), 64'h0);
    tick();
    rst_n = 1'b1;
    idle();
    #1;
    check("rst_pend_vec", 64'(bus.pend_vec), 64'h0);
    check("rst_r4", 64'(rdd(0)), 64'h0);
    check("rst_r5_cleared", 64'(rdd(1)), 64'h0);
    set_rd(0, 5'd9);
    set_rd(1, 5'd3);
    #1;
    check("rst_rd_pending", 64'(bus.rd_pending), 64'h0);
    check("rst_r9_cleared", 64'(rdd(0)), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 The block SHALL have parameter NREGS, default 32, register count (power of two, >=2); AW = log2(NREGS).
REQ-003 The block SHALL have parameter NRD, default 2, number of read ports.
REQ-004 The block SHALL have parameter NWR, default 2, number of write ports.
REQ-005 The block SHALL have parameter ZERO_REG, default 1, meaning register 0 is hardwired to zero when set.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 rst_n  input  1  reset; synchronous, active-low.
REQ-008 rd_addr  input  NRD*AW  read addresses, port i at bits [i*AW +: AW].
REQ-009 rd_data  output  NRD*XLEN  read data, port i at bits [i*XLEN +: XLEN].
REQ-010 rd_pending  output  NRD  per read port: source register awaits an outstanding write.
REQ-011 wr_en  input  NWR  per-port write enable.
REQ-012 wr_addr  input  NWR*AW  write addresses.
REQ-013 wr_data  input  NWR*XLEN  write data.
REQ-014 iss_en  input  1  issue strobe: marks iss_addr as having a pending producer.
REQ-015 iss_addr  input  AW  destination register of the issued instruction.
REQ-016 pend_vec  output  NREGS  registered scoreboard, one bit per register.

Function
REQ-017 Writes SHALL commit on the rising edge where wr_en[j]=1 and rst_n=1.
REQ-018 When several ports write the same address in one cycle, the highest-index port SHALL win.
REQ-019 With ZERO_REG=1, writes to address 0 SHALL be discarded and reads of address 0 SHALL return 0.
REQ-020 rd_data[i] SHALL be combinational: stored value, overridden by wr_data[j] of the highest-index j with wr_en[j]=1, wr_addr[j]==rd_addr[i], and address nonzero (when ZERO_REG=1); zero read latency.
REQ-021 pend_vec[a] SHALL be set on the edge after iss_en=1 with iss_addr=a.
REQ-022 pend_vec[a] SHALL be cleared on the edge after any wr_en[j]=1 with wr_addr[j]=a.
REQ-023 Simultaneous issue and write to the same address SHALL leave pend_vec[a]=1 (new producer wins).
REQ-024 rd_pending[i] SHALL equal pend_vec[rd_addr[i]], forced to 0 when a same-cycle write to that address is bypassed; a same-cycle issue SHALL NOT affect it.
REQ-025 With ZERO_REG=1, pend_vec[0] SHALL remain 0 and iss_en to address 0 SHALL be ignored.
REQ-026 Out-of-range addresses cannot occur (NREGS power of two); no error handling SHALL be provided.

Reset
REQ-027 On a rising edge with rst_n=0, all registers SHALL become 0 and pend_vec SHALL become 0.
REQ-028 While rst_n=0, writes and issues SHALL be ignored, bypass SHALL be disabled, and rd_data SHALL read 0 on every port.
REQ-029 Reset asserted mid-operation SHALL discard same-cycle writes and issues; rd_pending SHALL be 0 from the following cycle.

Structure
REQ-030 Package regfile_pkg SHALL hold XLEN, NREGS defaults and the AW derivation constant/function.
REQ-031 Per-read-port bypass/priority mux SHALL be a sub-module regfile_bypass, instantiated NRD times via generate.
REQ-032 Storage and scoreboard SHALL be plain flops in regfile_mp; no memory macro inference is required.

Verification
REQ-033 Reset, then read all 32 registers on both ports -> every rd_data 0, pend_vec 0.
REQ-034 wr_en=01, wr_addr[0]=5, wr_data=0xDEADBEEF, rd_addr[0]=5 same cycle -> rd_data[0]=0xDEADBEEF that cycle and on the next cycle from storage.
REQ-035 Both ports write addr 7 (0x11, 0x22) -> bypass and later read return 0x22.
REQ-036 Write 0xFFFF_FFFF to addr 0, issue addr 0 -> rd_data 0, pend_vec[0]=0.
REQ-037 Issue addr 9; next cycle rd_pending=1; write addr 9 with 0x55 and issue addr 9 same cycle -> rd_pending 0 and rd_data 0x55 that cycle, pend_vec[9]=1 on the next cycle.
REQ-038 Issue addr 3 and write addr 4 with rst_n=0 -> pend_vec 0, register 4 reads 0 after reset release.
